arb_req_queue: RTL and testbench

- Per-requestor request buffering and dispatch stage directly upstream and downstream of the weighted round-robin arbiter in the vector chip.
- Buffers up to FIFO_DEPTH entries from each of VECTOR_IN requestor channels. The non-empty status of each FIFO drives the arbiter's request_vector.
- Consumes the arbiter's one-hot grant. On each grant it pops the selected FIFO into a registered valid/ready output toward the shared resource (vector register file / memory port).

---
 rtl/arb_req_queue.sv | 118 +++++++++++
 tb/tb_arb_req_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_queue.sv
// Per-requestor FIFOs feeding a one-hot-granted dispatch register.
// request_vector exposes FIFO occupancy to the arbiter; grant selects the FIFO to pop.
module arb_req_queue #(
    parameter int VECTOR_IN  = 8,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [VECTOR_IN-1:0]         in_valid,
    output logic [VECTOR_IN-1:0]         in_ready,
    input  logic [DATA_W-1:0]            in_data [VECTOR_IN-1:0],
    output logic [VECTOR_IN-1:0]         request_vector,
    input  logic [VECTOR_IN-1:0]         grant,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(VECTOR_IN)-1:0] out_src,
    output logic                         grant_err
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int SRC_W = $clog2(VECTOR_IN);

    logic [DATA_W-1:0]    mem    [VECTOR_IN][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr [VECTOR_IN];
    logic [PTR_W-1:0]     rd_ptr [VECTOR_IN];

    logic [VECTOR_IN-1:0] full;
    logic [VECTOR_IN-1:0] empty;
    logic [VECTOR_IN-1:0] push;
    logic [VECTOR_IN-1:0] pop;
    logic                 grant_one_hot;
    logic                 grant_multi_hot;
    logic                 gvalid;
    logic                 out_free;
    logic                 pop_en;
    logic [SRC_W-1:0]     g_idx;

    // Occupancy flags come from registered pointers only, so a same-cycle pop
    // never opens space for a push into a full FIFO.
    always_comb begin
        for (int i = 0; i < VECTOR_IN; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        end
    end

    assign in_ready       = ~full;
    assign request_vector = ~empty;
    assign push           = in_valid & in_ready;

    assign grant_one_hot   = (grant != '0) && ((grant & (grant - VECTOR_IN'(1))) == '0);
    assign grant_multi_hot = (grant != '0) && !grant_one_hot;
    assign gvalid          = grant_one_hot && ((grant & request_vector) != '0);
    assign out_free        = !out_valid || out_ready;
    assign pop_en          = gvalid && out_free;
    assign pop             = pop_en ? grant : '0;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < VECTOR_IN; i++) begin
            if (grant[i]) begin
                g_idx = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < VECTOR_IN; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < VECTOR_IN; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
            end
        end
    end

    // Storage is not reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < VECTOR_IN; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            grant_err <= 1'b0;
        end else begin
            if (pop_en) begin
                out_valid <= 1'b1;
                out_data  <= mem[g_idx][rd_ptr[g_idx][AW-1:0]];
                out_src   <= g_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (grant_multi_hot) begin
                grant_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the request buffers and output stage.
module tb_arb_req_queue;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  in_valid = '0;
    logic [N-1:0]  in_ready;
    logic [DW-1:0] in_data [N-1:0];
    logic [N-1:0]  request_vector;
    logic [N-1:0]  grant = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic          grant_err;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] q [N][$];
    logic          m_ov  = 1'b0;
    logic [DW-1:0] m_od  = '0;
    logic [1:0]    m_src = '0;
    logic          m_err = 1'b0;

    arb_req_queue #(.VECTOR_IN(N), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .request_vector(request_vector), .grant(grant),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model_req();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = (q[i].size() != 0);
        return r;
    endfunction

    function automatic logic [N-1:0] model_rdy();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = (q[i].size() < D);
        return r;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),       32'(model_rdy()));
        chk({tag, ".req"},       32'(request_vector), 32'(model_req()));
        chk({tag, ".out_valid"}, 32'(out_valid),      32'(m_ov));
        chk({tag, ".out_data"},  32'(out_data),       32'(m_od));
        chk({tag, ".out_src"},   32'(out_src),        32'(m_src));
        chk({tag, ".grant_err"}, 32'(grant_err),      32'(m_err));
    endtask

    // One clock: check at the falling edge, then advance the model across the rising edge.
    task automatic tick(input string tag);
        int           ones;
        int           g;
        logic         do_pop;
        logic [N-1:0] req;
        logic [N-1:0] acc;
        @(negedge clk);
        check_all(tag);
        ones = $countones(grant);
        g = 0;
        for (int i = 0; i < N; i++) if (grant[i]) g = i;
        req    = model_req();
        acc    = in_valid & model_rdy();
        do_pop = (ones == 1) && ((grant & req) != 0) && (!m_ov || out_ready);
        @(posedge clk);
        if (do_pop) begin
            m_od  = q[g].pop_front();
            m_src = 2'(g);
            m_ov  = 1'b1;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (ones > 1) m_err = 1'b1;
        for (int i = 0; i < N; i++) if (acc[i]) q[i].push_back(in_data[i]);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        #2;
        for (int i = 0; i < N; i++) q[i].delete();
        m_ov = 1'b0; m_od = '0; m_src = '0; m_err = 1'b0;
        chk({tag, ".rst_out_valid"}, 32'(out_valid),      32'd0);
        chk({tag, ".rst_req"},       32'(request_vector), 32'd0);
        chk({tag, ".rst_err"},       32'(grant_err),      32'd0);
        chk({tag, ".rst_data"},      32'(out_data),       32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        chk({tag, ".rel_in_ready"},  32'(in_ready),       32'hF);
    endtask

    initial begin
        for (int i = 0; i < N; i++) in_data[i] = '0;
        #12;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.req",       32'(request_vector), 32'd0);
        chk("reset.out_src",   32'(out_src), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick("idle");

        // single request on channel 2
        in_valid = 4'b0100; in_data[2] = 16'hA001;
        tick("t1_push");
        in_valid = '0;
        chk("t1.req_after_push", 32'(request_vector), 32'b0100);
        tick("t1_wait");
        grant = 4'b0100;
        tick("t1_grant");
        grant = '0;
        chk("t1.out_data", 32'(out_data), 32'hA001);
        chk("t1.out_src",  32'(out_src),  32'd2);
        chk("t1.req_clear", 32'(request_vector), 32'd0);
        tick("t1_drain");

        // fill channel 0 beyond depth, then drain in order
        in_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            in_data[0] = 16'(16'h0010 + k);
            tick("t2_fill");
        end
        in_valid = '0;
        chk("t2.in_ready_full", 32'(in_ready[0]), 32'd0);
        grant = 4'b0001; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick("t2_drain");
        grant = '0;
        tick("t2_idle");

        // backpressure on channel 1
        in_valid = 4'b0010; in_data[1] = 16'h0B0B;
        tick("t3_push0");
        in_data[1] = 16'h0B0C;
        tick("t3_push1");
        in_valid = '0; out_ready = 1'b0; grant = 4'b0010;
        for (int k = 0; k < 6; k++) tick("t3_hold");
        chk("t3.held_data", 32'(out_data), 32'h0B0B);
        out_ready = 1'b1;
        tick("t3_release");
        chk("t3.next_data", 32'(out_data), 32'h0B0C);
        grant = '0;
        tick("t3_idle");

        // empty-target grant
        grant = 4'b1000;
        tick("t5_stale");
        tick("t5_stale2");
        grant = '0;

        // multi-hot grant, then reset
        in_valid = 4'b0110; in_data[1] = 16'h1111; in_data[2] = 16'h2222;
        tick("t4_push");
        in_valid = '0;
        grant = 4'b0110;
        tick("t4_multi");
        grant = '0;
        chk("t4.err_set", 32'(grant_err), 32'd1);
        tick("t4_sticky");
        tick("t4_sticky2");
        apply_reset("t4");

        // reset mid-dispatch with channels 0 and 3 loaded
        in_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            in_data[0] = 16'(16'hC000 + k); in_data[3] = 16'(16'hD000 + k);
            tick("t6_fill");
        end
        in_valid = '0; grant = 4'b0001;
        tick("t6_pop0");
        grant = 4'b1000;
        tick("t6_pop1");
        grant = '0;
        apply_reset("t6");
        tick("t6_after");
        chk("t6.out_data_zero", 32'(out_data), 32'd0);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            int sel;
            for (int i = 0; i < N; i++) in_data[i] = 16'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 99);
            if (sel < 15)       grant = '0;
            else if (sel < 98)  grant = 4'(1 << $urandom_range(0, N - 1));
            else                grant = 4'b0101;
            if (c == 300) begin
                grant = '0;
                apply_reset("rnd");
            end
            tick("rnd");
        end
        in_valid = '0; grant = '0; out_ready = 1'b1;
        tick("end");
        tick("end2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
